// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ
// byte-stream requesters. A requester keeps the transmitter across a
// multi-byte message until it offers a byte flagged req_last. Bytes are
// launched with a one-cycle tx_start pulse and completion is tracked on
// tx_busy, with a fault pulse if the transmitter never acknowledges.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    grant_active,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state_reg;
    logic [IDW-1:0]  ptr_reg;
    logic            last_reg;
    logic [CW-1:0]   cnt_reg;

    logic [IDW-1:0]  cand_idx [NREQ];
    logic [NREQ-1:0] cand_valid;
    logic [7:0]      req_byte [NREQ];
    logic [IDW-1:0]  winner;
    logic            any_valid;
    logic [IDW:0]    grant_sum;
    logic [IDW-1:0]  ptr_next;

    // Candidate k is the requester k positions after ptr, wrapped modulo NREQ.
    // Only the current owner may see ready, and only while the line is free.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            logic [IDW:0] sum;
            assign sum            = {1'b0, ptr_reg} + (IDW+1)'(gi);
            assign cand_idx[gi]   = (sum >= (IDW+1)'(NREQ)) ?
                                    IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
            assign req_byte[gi]   = req_data[8*gi +: 8];
            assign req_ready[gi]  = (state_reg == SEND) &&
                                    (grant_id == IDW'(gi)) && !tx_busy;
        end
    endgenerate

    // Pick the first valid candidate in rotation order; scanning from the far
    // end lets the nearest candidate overwrite the others.
    always_comb begin
        winner    = ptr_reg;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                winner    = cand_idx[k];
                any_valid = 1'b1;
            end
        end
    end

    // The requester after the current owner becomes the next scan start, so a
    // requester that just finished ranks last in the following arbitration.
    assign grant_sum = {1'b0, grant_id} + (IDW+1)'(1);
    assign ptr_next  = (grant_sum >= (IDW+1)'(NREQ)) ? '0 : grant_sum[IDW-1:0];

    // Arbitration / transmit-handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            last_reg     <= 1'b0;
            cnt_reg      <= '0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            grant_active <= 1'b0;
            grant_id     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_valid && !tx_busy) begin
                        grant_id     <= winner;
                        grant_active <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (req_valid[grant_id] && req_ready[grant_id]) begin
                        tx_data   <= req_byte[grant_id];
                        last_reg  <= req_last[grant_id];
                        tx_start  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // An acknowledge in the final cycle still beats the fault.
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (cnt_reg == CW'(BUSY_TIMEOUT - 1)) begin
                        timeout_err  <= 1'b1;
                        grant_active <= 1'b0;
                        ptr_reg      <= ptr_next;
                        state_reg    <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_reg) begin
                            grant_active <= 1'b0;
                            ptr_reg      <= ptr_next;
                            state_reg    <= IDLE;
                        end else begin
                            state_reg <= SEND;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model that
// raises tx_busy one cycle after tx_start for busy_len cycles.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              grant_active;
    logic [IDW-1:0]    grant_id;
    logic              timeout_err;

    int   compared   = 0;
    int   mismatched = 0;
    int   busy_len   = 3;
    logic ack_en     = 1'b1;
    logic force_busy = 1'b0;
    int   busy_cnt;
    int   to_pulses  = 0;
    int   n;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  busy_cnt <= 0;
        else if (tx_start && ack_en) busy_cnt <= busy_len;
        else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    // Count timeout pulses over the whole run.
    always @(posedge clk) begin
        if (timeout_err) to_pulses <= to_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Step negedges until tx_start is seen (at least one step), bounded.
    task automatic wait_start(input string tag, input int maxc, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tx_start && cnt < maxc);
        chk(tag, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic level, input int maxc);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (tx_busy !== level && c < maxc);
        chk(tag, 32'(tx_busy), 32'(level));
    endtask

    task automatic wait_released(input string tag, input int maxc);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (grant_active && c < maxc);
        chk(tag, 32'(grant_active), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset values
        @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_grant_act", 32'(grant_active), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte from requester 1, long transmit
        busy_len        = 160;
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'hA5;
        req_last        = 4'b0010;
        @(negedge clk);
        chk("sb_ready", 32'(req_ready), 32'b0010);
        chk("sb_grant_id", 32'(grant_id), 32'd1);
        chk("sb_grant_act", 32'(grant_active), 32'd1);
        chk("sb_no_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("sb_start", 32'(tx_start), 32'd1);
        chk("sb_data", 32'(tx_data), 32'hA5);
        req_valid = '0;
        @(negedge clk);
        chk("sb_one_pulse", 32'(tx_start), 32'd0);
        wait_busy("sb_busy_hi", 1'b1, 10);
        wait_busy("sb_busy_lo", 1'b0, 200);
        chk("sb_held", 32'(grant_active), 32'd1);
        @(negedge clk);
        chk("sb_released", 32'(grant_active), 32'd0);
        chk("sb_id_hold", 32'(grant_id), 32'd1);

        // ptr is now 2: requests 0 and 2 -> 2 wins; then reset in WAIT_DONE
        busy_len       = 3;
        req_valid      = 4'b0101;
        req_last       = 4'b1111;
        req_data[7:0]  = 8'h10;
        req_data[15:8] = 8'h11;
        req_data[23:16]= 8'h12;
        req_data[31:24]= 8'h13;
        wait_start("ptr_start", 10, n);
        chk("ptr_grant_id", 32'(grant_id), 32'd2);
        chk("ptr_data", 32'(tx_data), 32'h12);
        @(negedge clk);
        @(negedge clk);
        chk("wd_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_act", 32'(grant_active), 32'd0);
        chk("mid_rst_id", 32'(grant_id), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'h00);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start("rr_start0", 10, n);
        chk("rr_lat", 32'(n), 32'd2);
        chk("rr_id0", 32'(grant_id), 32'd0);
        chk("rr_data0", 32'(tx_data), 32'h10);

        // Round-robin with all four requesting continuously
        req_valid = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] exp_id;
            exp_id = 2'(k % 4);
            wait_start("rr_start", 20, n);
            chk("rr_gap", 32'(n), 32'd7);
            chk("rr_id", 32'(grant_id), 32'(exp_id));
            chk("rr_data", 32'(tx_data), 32'h10 + 32'(exp_id));
        end
        req_valid = '0;
        wait_released("rr_done", 20);

        // Locked message from 2 (48, 69 last), then 3, then 2 again (0A)
        req_valid       = 4'b1100;
        req_data[23:16] = 8'h48;
        req_data[31:24] = 8'h33;
        req_last        = 4'b1000;
        wait_start("lk_start1", 20, n);
        chk("lk_id1", 32'(grant_id), 32'd2);
        chk("lk_data1", 32'(tx_data), 32'h48);
        req_data[23:16] = 8'h69;
        req_last        = 4'b1100;
        wait_start("lk_start2", 20, n);
        chk("lk_gap2", 32'(n), 32'd6);
        chk("lk_id2", 32'(grant_id), 32'd2);
        chk("lk_data2", 32'(tx_data), 32'h69);
        req_data[23:16] = 8'h0A;
        wait_start("lk_start3", 20, n);
        chk("lk_gap3", 32'(n), 32'd7);
        chk("lk_id3", 32'(grant_id), 32'd3);
        chk("lk_data3", 32'(tx_data), 32'h33);
        req_valid = 4'b0100;
        wait_start("lk_start4", 20, n);
        chk("lk_id4", 32'(grant_id), 32'd2);
        chk("lk_data4", 32'(tx_data), 32'h0A);
        req_valid = '0;
        wait_released("lk_done", 20);

        // Timeout: transmitter never acknowledges; ptr=3 -> 0 first, then 1
        ack_en         = 1'b0;
        req_valid      = 4'b0011;
        req_data[7:0]  = 8'h40;
        req_data[15:8] = 8'h41;
        req_last       = 4'b0011;
        wait_start("to_start", 20, n);
        chk("to_id", 32'(grant_id), 32'd0);
        req_valid = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 40);
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_delay", 32'(n), 32'd16);
        chk("to_released", 32'(grant_active), 32'd0);
        ack_en = 1'b1;
        @(negedge clk);
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_next_act", 32'(grant_active), 32'd1);
        chk("to_next_id", 32'(grant_id), 32'd1);
        wait_start("to_next_start", 10, n);
        chk("to_next_data", 32'(tx_data), 32'h41);
        req_valid = '0;
        wait_released("to_done", 20);

        // Busy at arbitration: nothing granted until busy falls
        force_busy    = 1'b1;
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h50;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bz_ready", 32'(req_ready), 32'd0);
            chk("bz_start", 32'(tx_start), 32'd0);
        end
        force_busy = 1'b0;
        wait_start("bz_start_after", 10, n);
        chk("bz_lat", 32'(n), 32'd2);
        chk("bz_id", 32'(grant_id), 32'd0);
        chk("bz_data", 32'(tx_data), 32'h50);
        req_valid = '0;
        wait_released("bz_done", 20);

        chk("timeout_count", 32'(to_pulses), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
